// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state/tx-source encodings and width limits for the UART transmitter
// Optional feature macro: UART_TX_BREAK_EN (adds the BREAK and BREAK_MARK states).
package uart_pkg;

    localparam int MIN_DATA_WIDTH = 5;
    localparam int MAX_DATA_WIDTH = 9;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        ARMED  = 4'd1,
        START  = 4'd2,
        DATA   = 4'd3,
        PARITY = 4'd4,
        STOP1  = 4'd5,
        STOP2  = 4'd6
`ifdef UART_TX_BREAK_EN
        ,
        BREAK      = 4'd7,
        BREAK_MARK = 4'd8
`endif
    } tx_state_e;

    typedef enum logic [2:0] {
        TX_SRC_IDLE   = 3'd0,
        TX_SRC_START  = 3'd1,
        TX_SRC_DATA   = 3'd2,
        TX_SRC_PARITY = 3'd3,
        TX_SRC_BREAK  = 3'd4
    } tx_src_e;

    // Line source for a given state; everything not listed sits at the idle level.
    function automatic tx_src_e tx_src_of(input tx_state_e st);
        case (st)
            START:      return TX_SRC_START;
            DATA:       return TX_SRC_DATA;
            PARITY:     return TX_SRC_PARITY;
`ifdef UART_TX_BREAK_EN
            BREAK:      return TX_SRC_BREAK;
`endif
            default:    return TX_SRC_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// rtl/uart_tx_shifter.sv - word holding register, bit index counter and parity XOR
// Ports:
//   UCLK, reset      clock, asynchronous active-low reset
//   load             capture data_in / parity_odd (a transfer)
//   data_in          word to hold
//   parity_odd       parity sense captured with the word
//   idx_clear        clear the bit index (entry to DATA)
//   idx_inc          advance the bit index (DATA baud_tick)
//   idx_last         current index addresses the final data bit
//   next_bit         word bit at the index the counter holds after this edge
//   parity_bit       XOR of the held word, inverted for odd parity
module uart_tx_shifter
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
)
(
    input  logic                  UCLK,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  parity_odd,
    input  logic                  idx_clear,
    input  logic                  idx_inc,
    output logic                  idx_last,
    output logic                  next_bit,
    output logic                  parity_bit
);

    localparam int IDX_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] word_q;
    logic                  par_odd_q;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_d;

    always_comb begin
        idx_d = idx_q;
        if (idx_clear) begin
            idx_d = '0;
        end else if (idx_inc) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge UCLK or negedge reset) begin
        if (!reset) begin
            word_q    <= '0;
            par_odd_q <= 1'b0;
            idx_q     <= '0;
        end else begin
            idx_q <= idx_d;
            if (load) begin
                word_q    <= data_in;
                par_odd_q <= parity_odd;
            end
        end
    end

    assign idx_last = (idx_q == IDX_W'(DATA_WIDTH - 1));

    // The core registers tx from the post-edge index, so look ahead through idx_d.
    // Past the last bit (non-power-of-two widths) the value is never used.
    assign next_bit = (32'(idx_d) < DATA_WIDTH) ? word_q[idx_d] : 1'b0;

    assign parity_bit = (^word_q) ^ par_odd_q;

endmodule

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART transmit FSM with registered serial output
// Optional feature macro: UART_TX_BREAK_EN (adds send_break input and break states).
// Ports:
//   UCLK, reset                       clock, asynchronous active-low reset
//   baud_tick                         one-cycle pulse per bit period
//   data_in, data_valid, data_ready   word handshake (transfer on valid & ready)
//   parity_enable, parity_odd         parity insertion and sense, captured per word
//   two_stop                          two stop bits when set, captured per word
//   send_break                        (UART_TX_BREAK_EN only) hold line at break level
//   tx                                registered serial line
//   busy                              frame pending or in flight
//   frame_done                        one-cycle pulse after the final stop bit ends
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int   DATA_WIDTH = 8,
    parameter logic IDLE_LEVEL = 1'b1
)
(
    input  logic                  UCLK,
    input  logic                  reset,
    input  logic                  baud_tick,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic                  parity_enable,
    input  logic                  parity_odd,
    input  logic                  two_stop,
`ifdef UART_TX_BREAK_EN
    input  logic                  send_break,
`endif
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    tx_state_e state_q;
    tx_state_e state_d;
    logic      tx_q;
    logic      tx_d;
    logic      frame_done_q;
    logic      frame_done_d;
    logic      pend_q;          // a word has been accepted and not yet started
    logic      par_en_q;
    logic      two_stop_q;      // stop-bit count of the frame on the line
    logic      two_stop_pend_q; // stop-bit count of the accepted word

    logic      xfer;
    logic      final_stop;
    logic      accept_slot;
    logic      word_avail;
    logic      start_entry;
    logic      idx_last;
    logic      next_bit;
    logic      parity_bit;

    // The stop-bit count of the next word is kept apart so that accepting it
    // during STOP1 cannot turn the current final stop into a non-final one.
    assign final_stop  = (state_q == STOP2) || ((state_q == STOP1) && !two_stop_q);
`ifdef UART_TX_BREAK_EN
    assign accept_slot = (state_q == IDLE) || final_stop || (state_q == BREAK_MARK);
`else
    assign accept_slot = (state_q == IDLE) || final_stop;
`endif
    assign data_ready  = accept_slot && !pend_q;
    assign xfer        = data_valid && data_ready;
    assign word_avail  = pend_q || xfer;
    assign start_entry = (state_d == START) && (state_q != START);

    uart_tx_shifter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shifter (
        .UCLK       (UCLK),
        .reset      (reset),
        .load       (xfer),
        .data_in    (data_in),
        .parity_odd (parity_odd),
        .idx_clear  ((state_q == START) && baud_tick),
        .idx_inc    ((state_q == DATA) && baud_tick),
        .idx_last   (idx_last),
        .next_bit   (next_bit),
        .parity_bit (parity_bit)
    );

    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                // A transfer wins over a coincident tick; START waits for the next tick.
                if (xfer) begin
                    state_d = ARMED;
                end
`ifdef UART_TX_BREAK_EN
                else if (send_break && baud_tick) begin
                    state_d = BREAK;
                end
`endif
            end
            ARMED: begin
                if (baud_tick) state_d = START;
            end
            START: begin
                if (baud_tick) state_d = DATA;
            end
            DATA: begin
                if (baud_tick && idx_last) state_d = par_en_q ? PARITY : STOP1;
            end
            PARITY: begin
                if (baud_tick) state_d = STOP1;
            end
            STOP1, STOP2: begin
                if (baud_tick) begin
                    if (!final_stop) begin
                        state_d = STOP2;
                    end else begin
                        frame_done_d = 1'b1;
                        state_d      = word_avail ? START : IDLE;
`ifdef UART_TX_BREAK_EN
                        if (send_break) state_d = BREAK;
`endif
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            BREAK: begin
                if (baud_tick && !send_break) state_d = BREAK_MARK;
            end
            BREAK_MARK: begin
                if (baud_tick) state_d = word_avail ? START : IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_d = IDLE_LEVEL;
        case (tx_src_of(state_d))
            TX_SRC_START:  tx_d = ~IDLE_LEVEL;
            TX_SRC_BREAK:  tx_d = ~IDLE_LEVEL;
            TX_SRC_DATA:   tx_d = next_bit;
            TX_SRC_PARITY: tx_d = parity_bit;
            default:       tx_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge UCLK or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            tx_q            <= IDLE_LEVEL;
            frame_done_q    <= 1'b0;
            pend_q          <= 1'b0;
            par_en_q        <= 1'b0;
            two_stop_q      <= 1'b0;
            two_stop_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_q         <= tx_d;
            frame_done_q <= frame_done_d;
            if (xfer) begin
                par_en_q        <= parity_enable;
                two_stop_pend_q <= two_stop;
            end
            if (start_entry) begin
                two_stop_q <= xfer ? two_stop : two_stop_pend_q;
                pend_q     <= 1'b0;
            end else if (xfer) begin
                pend_q <= 1'b1;
            end
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - directed self-checking bench for uart_tx_core (8-bit and 5-bit instances)
module tb_uart_tx_core;

    logic       UCLK = 1'b0;
    logic       reset;
    logic       baud_tick;

    logic [7:0] d8;
    logic       v8, r8, pe8, po8, ts8, tx8, busy8, fd8;
    logic [4:0] d5;
    logic       v5, r5, pe5, po5, ts5, tx5, busy5, fd5;
`ifdef UART_TX_BREAK_EN
    logic       sb8, sb5;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int fd8_cnt  = 0;
    int fd5_cnt  = 0;
    int tick_cnt = 0;
    int base     = 0;

    always #5 UCLK = ~UCLK;

    uart_tx_core #(.DATA_WIDTH(8), .IDLE_LEVEL(1'b1)) dut8 (
        .UCLK          (UCLK),
        .reset         (reset),
        .baud_tick     (baud_tick),
        .data_in       (d8),
        .data_valid    (v8),
        .data_ready    (r8),
        .parity_enable (pe8),
        .parity_odd    (po8),
        .two_stop      (ts8),
`ifdef UART_TX_BREAK_EN
        .send_break    (sb8),
`endif
        .tx            (tx8),
        .busy          (busy8),
        .frame_done    (fd8)
    );

    uart_tx_core #(.DATA_WIDTH(5), .IDLE_LEVEL(1'b1)) dut5 (
        .UCLK          (UCLK),
        .reset         (reset),
        .baud_tick     (baud_tick),
        .data_in       (d5),
        .data_valid    (v5),
        .data_ready    (r5),
        .parity_enable (pe5),
        .parity_odd    (po5),
        .two_stop      (ts5),
`ifdef UART_TX_BREAK_EN
        .send_break    (sb5),
`endif
        .tx            (tx5),
        .busy          (busy5),
        .frame_done    (fd5)
    );

    // baud_tick: one cycle high every 16 cycles, changed on the falling edge
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(negedge UCLK);
            tick_cnt  = (tick_cnt == 15) ? 0 : tick_cnt + 1;
            baud_tick = (tick_cnt == 15);
        end
    end

    initial begin
        forever begin
            @(negedge UCLK);
            if (fd8 === 1'b1) fd8_cnt++;
            if (fd5 === 1'b1) fd5_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_tx(input int w);
        return (w == 5) ? tx5 : tx8;
    endfunction

    function automatic logic get_ready(input int w);
        return (w == 5) ? r5 : r8;
    endfunction

    // Returns 2 time units after the next clock edge that sees baud_tick high.
    task automatic wait_tick(input string tag);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < 64) begin
            @(posedge UCLK);
            n++;
            if (baud_tick === 1'b1) seen = 1'b1;
        end
        #2;
        chk({tag, "_tick"}, 32'(seen), 1);
    endtask

    // bits[i] is the i-th level on the line: checked at the start and middle of its period.
    task automatic check_bits(input int w, input logic [15:0] bits, input int first,
                              input int last, input string tag);
        for (int i = first; i <= last; i++) begin
            wait_tick(tag);
            chk($sformatf("%s_bit%0d", tag, i), 32'(get_tx(w)), 32'(bits[i]));
            repeat (8) @(negedge UCLK);
            chk($sformatf("%s_hold%0d", tag, i), 32'(get_tx(w)), 32'(bits[i]));
        end
    endtask

    // align=1 places the transfer on the same edge as a baud_tick.
    task automatic send(input int w, input logic [7:0] word, input logic pe, input logic po,
                        input logic ts, input bit align, input string tag);
        int n = 0;
        @(negedge UCLK); #1;
        if (align) begin
            while (baud_tick !== 1'b1 && n < 40) begin
                @(negedge UCLK); #1;
                n++;
            end
        end
        if (w == 5) begin
            d5 = word[4:0]; pe5 = pe; po5 = po; ts5 = ts; v5 = 1'b1;
        end else begin
            d8 = word; pe8 = pe; po8 = po; ts8 = ts; v8 = 1'b1;
        end
        n = 0;
        while (get_ready(w) !== 1'b1 && n < 400) begin
            @(negedge UCLK); #1;
            n++;
        end
        chk({tag, "_ready"}, 32'(get_ready(w)), 1);
        @(negedge UCLK); #1;
        v5 = 1'b0;
        v8 = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        d8 = '0; v8 = 1'b0; pe8 = 1'b0; po8 = 1'b0; ts8 = 1'b0;
        d5 = '0; v5 = 1'b0; pe5 = 1'b0; po5 = 1'b0; ts5 = 1'b0;
`ifdef UART_TX_BREAK_EN
        sb8 = 1'b0; sb5 = 1'b0;
`endif
        repeat (3) @(negedge UCLK); #1;
        chk("rst_tx8", 32'(tx8), 1);
        chk("rst_busy8", 32'(busy8), 0);
        chk("rst_ready8", 32'(r8), 1);
        chk("rst_done8", 32'(fd8), 0);
        chk("rst_tx5", 32'(tx5), 1);
        chk("rst_busy5", 32'(busy5), 0);
        chk("rst_ready5", 32'(r5), 1);
        reset = 1'b1;

        // idle: ticks are ignored
        repeat (40) @(negedge UCLK); #1;
        chk("idle_busy8", 32'(busy8), 0);
        chk("idle_tx8", 32'(tx8), 1);

        // 8N1 0xA5, transfer coincident with a tick; inputs changed mid-frame
        base = fd8_cnt;
        send(8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, "a5");
        chk("a5_armed_busy", 32'(busy8), 1);
        chk("a5_armed_tx", 32'(tx8), 1);
        chk("a5_armed_ready", 32'(r8), 0);
        d8 = 8'h00; pe8 = 1'b1; po8 = 1'b1; ts8 = 1'b1;
        check_bits(8, {6'b0, 1'b1, 8'hA5, 1'b0}, 0, 9, "a5");
        wait_tick("a5_end");
        chk("a5_done", 32'(fd8), 1);
        chk("a5_end_busy", 32'(busy8), 0);
        chk("a5_end_tx", 32'(tx8), 1);
        chk("a5_end_ready", 32'(r8), 1);
        repeat (20) @(negedge UCLK); #1;
        chk("a5_done_count", 32'(fd8_cnt - base), 1);

        // even parity 0x07 -> parity bit 1
        send(8, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, "ep");
        check_bits(8, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 0, 10, "ep");
        wait_tick("ep_end");
        chk("ep_done", 32'(fd8), 1);

        // odd parity 0x07 -> parity bit 0
        send(8, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0, "op");
        check_bits(8, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 0, 10, "op");
        wait_tick("op_end");
        chk("op_done", 32'(fd8), 1);

        // 5-bit word, two stop bits
        base = fd5_cnt;
        send(5, 8'h1F, 1'b0, 1'b0, 1'b1, 1'b0, "w5");
        check_bits(5, {8'b0, 1'b1, 1'b1, 5'h1F, 1'b0}, 0, 7, "w5");
        wait_tick("w5_end");
        chk("w5_done", 32'(fd5), 1);
        chk("w5_end_busy", 32'(busy5), 0);
        chk("w5_end_tx", 32'(tx5), 1);
        repeat (20) @(negedge UCLK); #1;
        chk("w5_done_count", 32'(fd5_cnt - base), 1);

        // back-to-back 0x55, 0xAA: 20 contiguous periods
        base = fd8_cnt;
        send(8, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, "b1");
        d8 = 8'hAA;
        v8 = 1'b1;
        check_bits(8, {6'b0, 1'b1, 8'h55, 1'b0}, 0, 8, "b1");
        wait_tick("b1_stop");
        chk("b1_stop_tx", 32'(tx8), 1);
        chk("b1_stop_ready", 32'(r8), 1);
        @(negedge UCLK); #1;
        @(negedge UCLK); #1;
        v8 = 1'b0;
        chk("b2_pending_ready", 32'(r8), 0);
        chk("b1_stop_tx_late", 32'(tx8), 1);
        wait_tick("b2_start");
        chk("b2_start_tx", 32'(tx8), 0);
        chk("b1_done", 32'(fd8), 1);
        chk("b2_start_busy", 32'(busy8), 1);
        check_bits(8, {6'b0, 1'b1, 8'hAA, 1'b0}, 1, 9, "b2");
        wait_tick("b2_end");
        chk("b2_done", 32'(fd8), 1);
        chk("b2_end_busy", 32'(busy8), 0);
        repeat (20) @(negedge UCLK); #1;
        chk("b2_done_count", 32'(fd8_cnt - base), 2);

        // reset during DATA bit 3
        send(8, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "rs");
        for (int i = 0; i < 5; i++) wait_tick("rs");
        chk("rs_bit3_tx", 32'(tx8), 0);
        chk("rs_bit3_busy", 32'(busy8), 1);
        base = fd8_cnt;
        #2;
        reset = 1'b0;
        #1;
        chk("rs_tx", 32'(tx8), 1);
        chk("rs_busy", 32'(busy8), 0);
        chk("rs_ready", 32'(r8), 1);
        chk("rs_done", 32'(fd8), 0);
        repeat (3) @(negedge UCLK);
        reset = 1'b1;
        repeat (48) @(negedge UCLK); #1;
        chk("rs_no_done", 32'(fd8_cnt - base), 0);
        chk("rs_after_busy", 32'(busy8), 0);
        chk("rs_after_tx", 32'(tx8), 1);

`ifdef UART_TX_BREAK_EN
        // break held for 30 ticks
        base = fd8_cnt;
        @(negedge UCLK); #1;
        sb8 = 1'b1;
        wait_tick("brk1");
        chk("brk_low1", 32'(tx8), 0);
        chk("brk_ready1", 32'(r8), 0);
        chk("brk_busy1", 32'(busy8), 1);
        for (int i = 2; i <= 30; i++) begin
            wait_tick("brk");
            chk($sformatf("brk_low%0d", i), 32'(tx8), 0);
        end
        chk("brk_ready30", 32'(r8), 0);
        @(negedge UCLK); #1;
        sb8 = 1'b0;
        wait_tick("brk_mark");
        chk("brk_mark_tx", 32'(tx8), 1);
        repeat (8) @(negedge UCLK);
        chk("brk_mark_hold", 32'(tx8), 1);
        wait_tick("brk_end");
        chk("brk_end_ready", 32'(r8), 1);
        chk("brk_end_busy", 32'(busy8), 0);
        chk("brk_end_tx", 32'(tx8), 1);
        chk("brk_no_done", 32'(fd8_cnt - base), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
